i2s_tx_scheduler: RTL and testbench

//  I2S transmit master for the codec DAC path. Divides the system clock into BCLK/LRCLK and serialises one

---
 rtl/i2s_tx_scheduler.sv | 164 ++++++++++++++++
 tb/tb_i2s_tx_scheduler.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_tx_scheduler.sv
// rtl/i2s_tx_scheduler.sv - I2S transmit master: BCLK/LRCLK divider, MSB-first serialiser, one-entry sample buffer
// Define I2S_UNDERRUN_CNT_EN to add the saturating underrun_cnt output.
module i2s_tx_scheduler #(
    parameter int SAMPLE_W  = 16,
    parameter int SLOT_BITS = 32,
    parameter int BCLK_DIV  = 4
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                EN,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [SAMPLE_W-1:0] s_left,
    input  logic [SAMPLE_W-1:0] s_right,
    output logic                BCLK,
    output logic                LRCLK,
    output logic                DACDAT,
    output logic                frame_start,
`ifdef I2S_UNDERRUN_CNT_EN
    output logic [15:0]         underrun_cnt,
`endif
    output logic                underrun
);
    localparam int FRAME_BITS = 2 * SLOT_BITS;
    localparam int B_W        = $clog2(FRAME_BITS);
    localparam int DIV_W      = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam logic [B_W-1:0]   B_LAST   = B_W'(FRAME_BITS - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);

    logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
    logic [B_W-1:0]      b_q, b_d;
    logic                bclk_q, bclk_d;
    logic                lrclk_q, lrclk_d;
    logic                dacdat_q, dacdat_d;
    logic                frame_start_q, frame_start_d;
    logic                underrun_q, underrun_d;
    logic                buf_full_q, buf_full_d;
    logic [SAMPLE_W-1:0] buf_l_q, buf_l_d, buf_r_q, buf_r_d;
    logic [SAMPLE_W-1:0] frame_l_q, frame_l_d, frame_r_q, frame_r_d;
    logic [SAMPLE_W-1:0] slot_word, shifted;
    logic [B_W-1:0]      k;

    always_comb begin
        div_cnt_d     = div_cnt_q;
        b_d           = b_q;
        bclk_d        = bclk_q;
        lrclk_d       = lrclk_q;
        dacdat_d      = dacdat_q;
        frame_start_d = 1'b0;
        underrun_d    = 1'b0;
        buf_full_d    = buf_full_q;
        buf_l_d       = buf_l_q;
        buf_r_d       = buf_r_q;
        frame_l_d     = frame_l_q;
        frame_r_d     = frame_r_q;
        slot_word     = '0;
        shifted       = '0;
        k             = '0;

        // Accept only into an empty buffer, consume only from a full one: they never collide.
        if (s_valid && !buf_full_q) begin
            buf_full_d = 1'b1;
            buf_l_d    = s_left;
            buf_r_d    = s_right;
        end

        if (!EN) begin
            div_cnt_d = '0;
            bclk_d    = 1'b0;
            lrclk_d   = 1'b0;
            dacdat_d  = 1'b0;
            b_d       = B_LAST;
        end else if (div_cnt_q == DIV_LAST) begin
            div_cnt_d = '0;
            bclk_d    = ~bclk_q;
            if (bclk_q) begin
                b_d     = (b_q == B_LAST) ? '0 : b_q + 1'b1;
                lrclk_d = (b_d >= B_W'(SLOT_BITS - 1)) && (b_d != B_LAST);
                if (b_d == '0) begin
                    frame_start_d = 1'b1;
                    if (buf_full_q) begin
                        frame_l_d  = buf_l_q;
                        frame_r_d  = buf_r_q;
                        buf_full_d = 1'b0;
                    end else begin
                        frame_l_d  = '0;
                        frame_r_d  = '0;
                        underrun_d = 1'b1;
                    end
                end
                if (b_d < B_W'(SLOT_BITS)) begin
                    slot_word = frame_l_d;
                    k         = b_d;
                end else begin
                    slot_word = frame_r_d;
                    k         = b_d - B_W'(SLOT_BITS);
                end
                // Shifting past the sample width leaves zeros, which are the pad bits.
                shifted  = slot_word << k;
                dacdat_d = shifted[SAMPLE_W-1];
            end
        end else begin
            div_cnt_d = div_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            div_cnt_q     <= '0;
            b_q           <= B_LAST;
            bclk_q        <= 1'b0;
            lrclk_q       <= 1'b0;
            dacdat_q      <= 1'b0;
            frame_start_q <= 1'b0;
            underrun_q    <= 1'b0;
            buf_full_q    <= 1'b0;
            buf_l_q       <= '0;
            buf_r_q       <= '0;
            frame_l_q     <= '0;
            frame_r_q     <= '0;
        end else begin
            div_cnt_q     <= div_cnt_d;
            b_q           <= b_d;
            bclk_q        <= bclk_d;
            lrclk_q       <= lrclk_d;
            dacdat_q      <= dacdat_d;
            frame_start_q <= frame_start_d;
            underrun_q    <= underrun_d;
            buf_full_q    <= buf_full_d;
            buf_l_q       <= buf_l_d;
            buf_r_q       <= buf_r_d;
            frame_l_q     <= frame_l_d;
            frame_r_q     <= frame_r_d;
        end
    end

`ifdef I2S_UNDERRUN_CNT_EN
    logic [15:0] ucnt_q, ucnt_d;

    always_comb begin
        ucnt_d = ucnt_q;
        if (underrun_d && (ucnt_q != 16'hFFFF)) begin
            ucnt_d = ucnt_q + 16'd1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ucnt_q <= '0;
        end else begin
            ucnt_q <= ucnt_d;
        end
    end

    assign underrun_cnt = ucnt_q;
`endif

    assign s_ready     = ~buf_full_q;
    assign BCLK        = bclk_q;
    assign LRCLK       = lrclk_q;
    assign DACDAT      = dacdat_q;
    assign frame_start = frame_start_q;
    assign underrun    = underrun_q;
endmodule

// File: tb/tb_i2s_tx_scheduler.sv
// tb/tb_i2s_tx_scheduler.sv - self-checking bench for i2s_tx_scheduler (default and fast-clock instances)
module tb_i2s_tx_scheduler;
    localparam int S     = 32;
    localparam int DIV   = 4;
    localparam int FRAME = 4 * DIV * S;

    typedef struct {
        logic        send;
        logic [15:0] l;
        logic [15:0] r;
    } vec_t;

    typedef struct {
        logic [15:0] l;
        logic [15:0] r;
        int          acc;
    } sb_t;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic        RST_N, EN, s_valid, s_ready, BCLK, LRCLK, DACDAT, frame_start, underrun;
    logic [15:0] s_left, s_right;
    logic        en2, s_valid2, s_ready2, bclk2, lrclk2, dacdat2, fs2, ur2;
    logic [15:0] s_left2, s_right2;
`ifdef I2S_UNDERRUN_CNT_EN
    logic [15:0] underrun_cnt, ucnt2;
`endif

    i2s_tx_scheduler #(.SAMPLE_W(16), .SLOT_BITS(S), .BCLK_DIV(DIV)) u_dut (
        .CLK(CLK), .RST_N(RST_N), .EN(EN), .s_valid(s_valid), .s_ready(s_ready),
        .s_left(s_left), .s_right(s_right), .BCLK(BCLK), .LRCLK(LRCLK), .DACDAT(DACDAT),
        .frame_start(frame_start),
`ifdef I2S_UNDERRUN_CNT_EN
        .underrun_cnt(underrun_cnt),
`endif
        .underrun(underrun)
    );

    i2s_tx_scheduler #(.SAMPLE_W(16), .SLOT_BITS(16), .BCLK_DIV(1)) u_fast (
        .CLK(CLK), .RST_N(RST_N), .EN(en2), .s_valid(s_valid2), .s_ready(s_ready2),
        .s_left(s_left2), .s_right(s_right2), .BCLK(bclk2), .LRCLK(lrclk2), .DACDAT(dacdat2),
        .frame_start(fs2),
`ifdef I2S_UNDERRUN_CNT_EN
        .underrun_cnt(ucnt2),
`endif
        .underrun(ur2)
    );

    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    sb_t  sb[$];
    int   fcnt = 0;
    bit   active = 0;
    logic [15:0] cur_l, cur_r;
    bit   cur_ur;
    int   ur_total = 0;
    int   last_fs_cyc = 0;
    int   mb, mph, mk;
    logic [15:0] mw;
    logic med;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge CLK) cyc <= cyc + 1;

    // Frame-level reference: pops the pair each boundary should consume and predicts every pin every CLK.
    always @(negedge CLK) begin
        if (!RST_N) begin
            sb.delete();
            active = 0;
            chk("reset_pins", {BCLK, LRCLK, DACDAT, frame_start, underrun, s_ready}, 6'b000001);
        end else begin
            if (!EN) begin
                active = 0;
                chk("idle_pins", {BCLK, LRCLK, DACDAT, frame_start, underrun}, 5'b0);
            end else begin
                if (frame_start) begin
                    if (active) chk("frame_len", fcnt, FRAME - 1);
                    cur_ur = !(sb.size() > 0 && sb[0].acc < cyc);
                    if (cur_ur) begin
                        cur_l = '0;
                        cur_r = '0;
                        ur_total++;
                    end else begin
                        cur_l = sb[0].l;
                        cur_r = sb[0].r;
                        void'(sb.pop_front());
                    end
                    last_fs_cyc = cyc;
                    fcnt = 0;
                    active = 1;
                end else if (active) begin
                    fcnt++;
                    if (fcnt >= FRAME) begin
                        chk("frame_start_missing", frame_start, 1'b1);
                        active = 0;
                    end
                end
                if (active) begin
                    mb  = fcnt / (2 * DIV);
                    mph = fcnt % (2 * DIV);
                    if (mb < S) begin
                        mw = cur_l;
                        mk = mb;
                    end else begin
                        mw = cur_r;
                        mk = mb - S;
                    end
                    med = (mk < 16) ? mw[15 - mk] : 1'b0;
                    chk("pins", {BCLK, LRCLK, DACDAT, frame_start, underrun},
                        {mph >= DIV, (mb >= S - 1) && (mb <= 2 * S - 2), med, fcnt == 0, (fcnt == 0) && cur_ur});
                end else begin
                    chk("startup_pins", {LRCLK, DACDAT, frame_start, underrun}, 4'b0);
                end
            end
            chk("s_ready", s_ready, !(sb.size() > 0 && sb[0].acc <= cyc));
        end
    end

    task automatic send(input logic [15:0] l, input logic [15:0] r, output int acc);
        int waited = 0;
        @(negedge CLK);
        #1;
        s_valid = 1'b1;
        s_left  = l;
        s_right = r;
        while (!s_ready && waited < 2000) begin
            @(negedge CLK);
            #1;
            waited++;
        end
        chk("send_ready", s_ready, 1'b1);
        acc = cyc + 1;
        if (s_ready) sb.push_back('{l, r, cyc + 1});
        @(posedge CLK);
        #1;
        s_valid = 1'b0;
        s_left  = 16'($urandom);
        s_right = 16'($urandom);
    endtask

    task automatic wait_fs(input int limit, output int n);
        n = 0;
        @(negedge CLK);
        n = 1;
        while (!frame_start && n < limit) begin
            @(negedge CLK);
            n++;
        end
        chk("fs_timeout", frame_start, 1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[8];
        int   n, acc, bad_bclk, bad_fs;
        bit   prev_send;
        logic [31:0] bits, lr;

        RST_N = 0; EN = 0; s_valid = 0; s_left = 0; s_right = 0;
        en2 = 0; s_valid2 = 0; s_left2 = 0; s_right2 = 0;
        vecs[0] = '{1'b1, 16'hA5C3, 16'h0F0F};
        vecs[1] = '{1'b1, 16'h8000, 16'h0001};
        vecs[2] = '{1'b1, 16'hFFFF, 16'h0000};
        vecs[3] = '{1'b1, 16'h1234, 16'hFEDC};
        vecs[4] = '{1'b0, 16'h0000, 16'h0000};
        vecs[5] = '{1'b0, 16'h0000, 16'h0000};
        vecs[6] = '{1'b0, 16'h0000, 16'h0000};
        vecs[7] = '{1'b1, 16'h7FFF, 16'h8001};

        repeat (3) @(negedge CLK);
        #1;
        chk("reset_state", {BCLK, LRCLK, DACDAT, frame_start, underrun, s_ready}, 6'b000001);
        RST_N = 1;

        // Pair buffered while idle, then enable: first boundary 8 CLK later carries it.
        send(vecs[0].l, vecs[0].r, acc);
        @(negedge CLK);
        #1 EN = 1;
        wait_fs(20, n);
        chk("start_latency", n, 8);
        chk("first_msb", DACDAT, 1'b1);

        prev_send = 0;
        for (int i = 1; i < 8; i++) begin
            if (vecs[i].send) begin
                send(vecs[i].l, vecs[i].r, acc);
                if (prev_send) chk("accept_after_fs", acc, last_fs_cyc + 1);
            end else begin
                wait_fs(600, n);
            end
            prev_send = vecs[i].send;
        end
        @(negedge CLK);
        #1;
`ifdef I2S_UNDERRUN_CNT_EN
        chk("underrun_cnt", underrun_cnt, ur_total);
`endif
        chk("underruns_seen", ur_total, 2);
        wait_fs(600, n);
        wait_fs(600, n);

        // Enable drop in the right slot, then restart with the buffered pair.
        send(16'hC001, 16'h3C3C, acc);
        repeat (300) @(negedge CLK);
        chk("pre_drop_lrclk", LRCLK, 1'b1);
        #1 EN = 0;
        @(negedge CLK);
        chk("en_low_pins", {BCLK, LRCLK, DACDAT}, 3'b000);
        chk("en_low_buffer_held", s_ready, 1'b0);
        repeat (4) @(negedge CLK);
        #1 EN = 1;
        wait_fs(20, n);
        chk("restart_latency", n, 8);
        chk("restart_msb", DACDAT, 1'b1);
        wait_fs(600, n);

        // Asynchronous reset mid-frame with a full buffer.
        send(16'h5A5A, 16'hA5A5, acc);
        repeat (300) @(negedge CLK);
        n = 0;
        while (!BCLK && n < 10) begin
            @(negedge CLK);
            n++;
        end
        chk("pre_reset_state", {BCLK, LRCLK, s_ready}, 3'b110);
        #1 RST_N = 0;
        #1;
        chk("async_reset", {BCLK, LRCLK, DACDAT, frame_start, underrun, s_ready}, 6'b000001);
`ifdef I2S_UNDERRUN_CNT_EN
        chk("reset_cnt", underrun_cnt, 16'd0);
`endif
        @(negedge CLK);
        #1;
        RST_N = 1;
        EN = 0;

        // Fast instance: BCLK every CLK, 16-bit slots, no pad bits.
        @(negedge CLK);
        #1;
        s_valid2 = 1; s_left2 = 16'h8000; s_right2 = 16'h0001;
        chk("t5_ready", s_ready2, 1'b1);
        @(posedge CLK);
        #1 s_valid2 = 0;
        @(negedge CLK);
        #1 en2 = 1;
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!fs2 && n < 20);
        chk("t5_latency", n, 2);
        bits = '0; lr = '0; bad_bclk = 0; bad_fs = 0;
        for (int i = 0; i < 64; i++) begin
            if (bclk2 !== 1'(i % 2)) bad_bclk++;
            if (i > 0 && fs2) bad_fs++;
            if (i % 2 == 0) begin
                bits[31 - i / 2] = dacdat2;
                lr[31 - i / 2]   = lrclk2;
            end
            @(negedge CLK);
        end
        chk("t5_bclk_toggle", bad_bclk, 0);
        chk("t5_no_early_fs", bad_fs, 0);
        chk("t5_data", bits, 32'h8000_0001);
        chk("t5_lrclk", lr, 32'h0001_FFFE);
        chk("t5_frame64", {fs2, ur2}, 2'b11);
`ifdef I2S_UNDERRUN_CNT_EN
        chk("t5_cnt", ucnt2, 16'd1);
`endif
        #1 en2 = 0;
        repeat (2) @(negedge CLK);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
